stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/debouncer.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and default timing constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } sw_state_e;

    // 20 ms debounce and 1 s long press at a 50 MHz clock.
    localparam int unsigned DefaultDebounceCyc = 1_000_000;
    localparam int unsigned DefaultLongCyc     = 50_000_000;

    function automatic logic state_counts(sw_state_e s);
        return (s == StRun) || (s == StLap);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;

    logic       btn_start_stop;
    logic       btn_lap_clear;
    logic       enable;
    logic       clear;
    logic       freeze;
    logic [1:0] state;

    // master drives the buttons, slave is the controller
    modport master (
        output btn_start_stop,
        output btn_lap_clear,
        input  enable,
        input  clear,
        input  freeze,
        input  state
    );

    modport slave (
        input  btn_start_stop,
        input  btn_lap_clear,
        output enable,
        output clear,
        output freeze,
        output state
    );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer, stability-count debouncer and one-cycle press pulse on rising edges.
module debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DefaultDebounceCyc
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw_i};
        cnt_d   = '0;
        level_d = level_q;
        // Count consecutive mismatch cycles; a matching cycle restarts the count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons, long-press clear, registered outputs.
// Define STOPWATCH_LAP_EN to enable the LAP state and the freeze output.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DefaultDebounceCyc,
    parameter int unsigned LONG_CYC     = DefaultLongCyc
) (
    input logic              clk,
    input logic              rst,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned LongW = $clog2(LONG_CYC + 1);
    localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYC - 1);
    localparam logic [LongW-1:0] LongMax  = LongW'(LONG_CYC);

    logic ss_level, ss_press;
    logic lap_level, lap_press;
    logic unused_ss_level;

    logic [LongW-1:0] long_cnt_q, long_cnt_d;
    logic             long_evt;

    sw_state_e state_q, state_d;
    logic      enable_q, enable_d;
    logic      clear_q, clear_d;

    debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_ss (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (bus.btn_start_stop),
        .level_o   (ss_level),
        .press_o   (ss_press)
    );

    debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_lap (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (bus.btn_lap_clear),
        .level_o   (lap_level),
        .press_o   (lap_press)
    );

    assign unused_ss_level = ss_level;

    // Saturating hold counter: fires once per hold, rearmed only by release.
    always_comb begin
        long_cnt_d = '0;
        long_evt   = 1'b0;
        if (lap_level) begin
            long_cnt_d = (long_cnt_q == LongMax) ? long_cnt_q : long_cnt_q + 1'b1;
            long_evt   = (long_cnt_q == LongLast);
        end
    end

    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (long_evt) begin
            state_d = StIdle;
            clear_d = 1'b1;
        end else if (ss_press) begin
            // start/stop wins over a coincident lap press
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                StLap:   state_d = StPause;
                default: state_d = StIdle;
            endcase
        end else if (lap_press) begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
`ifdef STOPWATCH_LAP_EN
                StRun:   state_d = StLap;
`else
                StRun:   state_d = StRun;
`endif
                StLap:   state_d = StRun;
                StPause: begin
                    state_d = StIdle;
                    clear_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
        enable_d = state_counts(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q <= '0;
            state_q    <= StIdle;
            enable_q   <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            state_q    <= state_d;
            enable_q   <= enable_d;
            clear_q    <= clear_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic freeze_q, freeze_d;

    assign freeze_d = (state_d == StLap);

    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end

    assign bus.freeze = freeze_q;
`else
    assign bus.freeze = 1'b0;
`endif

    assign bus.state  = state_q;
    assign bus.enable = enable_q;
    assign bus.clear  = clear_q;

endmodule
